// File: rtl/sdram_fb_arbiter.sv
// Shares one SDRAM Avalon-MM port between scanout (burst reads, priority) and raster (single beats).
// Optional grant/stall statistics are built when SDRAM_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no owner; arbitration sampled and grant registered
// G0     | scanout drives the command bus
// G1     | raster drives the command bus
// DRAIN0 | command issued, forwarding read beats to scanout
// DRAIN1 | command issued, forwarding the read beat to raster
module sdram_fb_arbiter #(
  parameter int AW         = 25,
  parameter int DW         = 32,
  parameter int BW         = 8,
  parameter int FAIR_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   s0_address,
  input  logic            s0_read,
  input  logic [BW-1:0]   s0_burstcount,
  output logic            s0_waitrequest,
  output logic [DW-1:0]   s0_readdata,
  output logic            s0_readdatavalid,
  input  logic [AW-1:0]   s1_address,
  input  logic            s1_read,
  input  logic            s1_write,
  input  logic [DW-1:0]   s1_writedata,
  input  logic [DW/8-1:0] s1_byteenable,
  output logic            s1_waitrequest,
  output logic [DW-1:0]   s1_readdata,
  output logic            s1_readdatavalid,
  output logic [AW-1:0]   m_address,
  output logic            m_read,
  output logic            m_write,
  output logic [DW-1:0]   m_writedata,
  output logic [DW/8-1:0] m_byteenable,
  output logic [BW-1:0]   m_burstcount,
  input  logic            m_waitrequest,
  input  logic [DW-1:0]   m_readdata,
  input  logic            m_readdatavalid
`ifdef SDRAM_ARB_STATS_EN
  ,
  input  logic            stat_clear,
  output logic [31:0]     stat_grant0,
  output logic [31:0]     stat_grant1,
  output logic [31:0]     stat_stall1
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_G0,
    ST_G1,
    ST_DRAIN0,
    ST_DRAIN1
  } state_t;

  localparam logic [7:0] FAIR_LIM = 8'(FAIR_LIMIT);

  state_t        state, state_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic [7:0]    streak, streak_nx;
  logic          s1_req;
  logic [BW-1:0] s0_bc_eff;

  assign s1_req    = s1_read | s1_write;
  // a zero burstcount from scanout is served as a single beat
  assign s0_bc_eff = (s0_burstcount == '0) ? BW'(1) : s0_burstcount;

  assign s0_readdata = m_readdata;
  assign s1_readdata = m_readdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      streak   <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_nx;
      streak   <= streak_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    beat_nx          = beat_cnt;
    streak_nx        = streak;
    m_address        = s0_address;
    m_read           = 1'b0;
    m_write          = 1'b0;
    m_writedata      = s1_writedata;
    m_byteenable     = '1;
    m_burstcount     = BW'(1);
    s0_waitrequest   = 1'b1;
    s1_waitrequest   = 1'b1;
    s0_readdatavalid = 1'b0;
    s1_readdatavalid = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s0_read && ((streak < FAIR_LIM) || !s1_req)) begin
          state_nx = ST_G0;
        end else if (s1_req) begin
          state_nx = ST_G1;
        end
      end

      ST_G0: begin
        m_address      = s0_address;
        m_read         = s0_read;
        m_burstcount   = s0_bc_eff;
        s0_waitrequest = m_waitrequest;
        if (!s0_read) begin
          state_nx = ST_IDLE;
        end else if (!m_waitrequest) begin
          beat_nx  = s0_bc_eff;
          state_nx = ST_DRAIN0;
          // streak only counts grants that made the raster wait
          if (s1_req) begin
            streak_nx = (streak == FAIR_LIM) ? streak : streak + 8'd1;
          end else begin
            streak_nx = '0;
          end
        end
      end

      ST_G1: begin
        m_address      = s1_address;
        m_write        = s1_write;
        m_read         = s1_read & ~s1_write;
        m_byteenable   = s1_byteenable;
        s1_waitrequest = m_waitrequest;
        if (!s1_req) begin
          state_nx = ST_IDLE;
        end else if (!m_waitrequest) begin
          streak_nx = '0;
          if (s1_write) begin
            state_nx = ST_IDLE;
          end else begin
            beat_nx  = BW'(1);
            state_nx = ST_DRAIN1;
          end
        end
      end

      ST_DRAIN0: begin
        s0_readdatavalid = m_readdatavalid;
        if (m_readdatavalid) begin
          beat_nx = beat_cnt - BW'(1);
          if (beat_cnt == BW'(1)) state_nx = ST_IDLE;
        end
      end

      ST_DRAIN1: begin
        s1_readdatavalid = m_readdatavalid;
        if (m_readdatavalid) begin
          beat_nx = beat_cnt - BW'(1);
          if (beat_cnt == BW'(1)) state_nx = ST_IDLE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef SDRAM_ARB_STATS_EN
  logic s0_accept, s1_accept;

  assign s0_accept = (state == ST_G0) && s0_read && !m_waitrequest;
  assign s1_accept = (state == ST_G1) && s1_req && !m_waitrequest;

  // clear wins over a coincident increment
  always_ff @(posedge clk) begin
    if (!reset_n || stat_clear) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_stall1 <= '0;
    end else begin
      if (s0_accept) stat_grant0 <= stat_grant0 + 32'd1;
      if (s1_accept) stat_grant1 <= stat_grant1 + 32'd1;
      if (s1_req && s1_waitrequest) stat_stall1 <= stat_stall1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// Self-checking bench for sdram_fb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an owner/beats-remaining transaction model.
module tb_sdram_fb_arbiter;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int FL = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [AW-1:0]   s0_address;
  logic            s0_read;
  logic [BW-1:0]   s0_burstcount;
  logic            s0_waitrequest;
  logic [DW-1:0]   s0_readdata;
  logic            s0_readdatavalid;
  logic [AW-1:0]   s1_address;
  logic            s1_read;
  logic            s1_write;
  logic [DW-1:0]   s1_writedata;
  logic [DW/8-1:0] s1_byteenable;
  logic            s1_waitrequest;
  logic [DW-1:0]   s1_readdata;
  logic            s1_readdatavalid;
  logic [AW-1:0]   m_address;
  logic            m_read;
  logic            m_write;
  logic [DW-1:0]   m_writedata;
  logic [DW/8-1:0] m_byteenable;
  logic [BW-1:0]   m_burstcount;
  logic            m_waitrequest;
  logic [DW-1:0]   m_readdata;
  logic            m_readdatavalid;
`ifdef SDRAM_ARB_STATS_EN
  logic            stat_clear;
  logic [31:0]     stat_grant0, stat_grant1, stat_stall1;
`endif

  always #5 clk = ~clk;

  sdram_fb_arbiter #(.AW(AW), .DW(DW), .BW(BW), .FAIR_LIMIT(FL)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_burstcount(s0_burstcount),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
`ifdef SDRAM_ARB_STATS_EN
    , .stat_clear(stat_clear), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
    .stat_stall1(stat_stall1)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: who owns the port, how many read beats are still owed, scanout streak.
  int  own = -1;
  int  beats_left = 0;
  int  streak = 0;
  bit  chk_en = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] mg0 = 0, mg1 = 0, ms1 = 0;
`endif

  always @(posedge clk) begin
    bit s1r, c0, c1, a0, a1;
    s1r = s1_read || s1_write;
    c0  = (own == 0) && (beats_left == 0);
    c1  = (own == 1) && (beats_left == 0);
    a0  = c0 && s0_read && !m_waitrequest;
    a1  = c1 && s1r && !m_waitrequest;
    if (!reset_n) begin
      own = -1; beats_left = 0; streak = 0;
`ifdef SDRAM_ARB_STATS_EN
      mg0 = 0; mg1 = 0; ms1 = 0;
`endif
    end else begin
`ifdef SDRAM_ARB_STATS_EN
      if (stat_clear) begin
        mg0 = 0; mg1 = 0; ms1 = 0;
      end else begin
        if (a0) mg0 = mg0 + 1;
        if (a1) mg1 = mg1 + 1;
        if (s1r && !(c1 && !m_waitrequest)) ms1 = ms1 + 1;
      end
`endif
      if (own < 0) begin
        if (s0_read && (streak < FL || !s1r)) own = 0;
        else if (s1r) own = 1;
      end else if (beats_left > 0) begin
        if (m_readdatavalid) begin
          beats_left--;
          if (beats_left == 0) own = -1;
        end
      end else if (own == 0) begin
        if (!s0_read) own = -1;
        else if (a0) begin
          beats_left = (s0_burstcount == 0) ? 1 : int'(s0_burstcount);
          streak = s1r ? streak + 1 : 0;
        end
      end else begin
        if (!s1r) own = -1;
        else if (a1) begin
          streak = 0;
          if (s1_write) own = -1;
          else beats_left = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit c0, c1, emr, emw;
    if (chk_en) begin
      c0  = (own == 0) && (beats_left == 0);
      c1  = (own == 1) && (beats_left == 0);
      emr = c0 ? s0_read : (c1 ? (s1_read && !s1_write) : 1'b0);
      emw = c1 ? s1_write : 1'b0;
      chk("m_read", m_read, emr);
      chk("m_write", m_write, emw);
      chk("s0_waitrequest", s0_waitrequest, c0 ? m_waitrequest : 1'b1);
      chk("s1_waitrequest", s1_waitrequest, c1 ? m_waitrequest : 1'b1);
      chk("s0_readdatavalid", s0_readdatavalid, (own == 0) && (beats_left > 0) && m_readdatavalid);
      chk("s1_readdatavalid", s1_readdatavalid, (own == 1) && (beats_left > 0) && m_readdatavalid);
      chk("s0_readdata", s0_readdata, m_readdata);
      chk("s1_readdata", s1_readdata, m_readdata);
      if (c0 && emr) begin
        chk("m_address_s0", m_address, s0_address);
        chk("m_burstcount_s0", m_burstcount, (s0_burstcount == 0) ? 1 : s0_burstcount);
        chk("m_byteenable_s0", m_byteenable, {(DW/8){1'b1}});
      end
      if (c1 && (emr || emw)) begin
        chk("m_address_s1", m_address, s1_address);
        chk("m_burstcount_s1", m_burstcount, 1);
        chk("m_byteenable_s1", m_byteenable, s1_byteenable);
        if (emw) chk("m_writedata", m_writedata, s1_writedata);
      end
      if (own < 0) chk("m_burstcount_idle", m_burstcount, 1);
`ifdef SDRAM_ARB_STATS_EN
      chk("stat_grant0", stat_grant0, mg0);
      chk("stat_grant1", stat_grant1, mg1);
      chk("stat_stall1", stat_stall1, ms1);
`endif
    end
  end

  // SDRAM controller emulation and master drivers.
  logic [DW-1:0] rq[$];
  logic [DW-1:0] s0_beats[$];
  int            gseq[$];
  int            s1_vcnt = 0;
  int            wait_pct = 0, rdv_pct = 100, force_wait = 0;
  bit            spurious_en = 0, auto_release = 1, rand_masters = 0, from_q = 0;
  bit            acc0 = 0, acc1 = 0;
  logic [31:0]   data_ctr = 32'h0;

  task automatic rand_drive();
    if (s0_read && (acc0 || $urandom_range(99) < 3)) s0_read = 1'b0;
    if (!s0_read && $urandom_range(99) < 40) begin
      s0_read = 1'b1;
      s0_address = AW'($urandom);
      s0_burstcount = BW'($urandom_range(0, 6));
    end
    if ((s1_read || s1_write) && (acc1 || $urandom_range(99) < 3)) begin
      s1_read = 1'b0;
      s1_write = 1'b0;
    end
    if (!s1_read && !s1_write && $urandom_range(99) < 30) begin
      case ($urandom_range(2))
        0: s1_read = 1'b1;
        1: s1_write = 1'b1;
        default: begin s1_read = 1'b1; s1_write = 1'b1; end
      endcase
      s1_address = AW'($urandom);
      s1_writedata = $urandom;
      s1_byteenable = (DW/8)'($urandom);
    end
`ifdef SDRAM_ARB_STATS_EN
    stat_clear = ($urandom_range(99) < 2);
`endif
  endtask

  task automatic tick_a();
    @(posedge clk);
    #1;
    if (force_wait > 0) begin
      m_waitrequest = 1'b1;
      force_wait--;
    end else begin
      m_waitrequest = ($urandom_range(99) < wait_pct);
    end
    from_q = 1'b0;
    if (rq.size() > 0 && $urandom_range(99) < rdv_pct) begin
      m_readdatavalid = 1'b1;
      m_readdata = rq[0];
      from_q = 1'b1;
    end else if (spurious_en && rq.size() == 0 && $urandom_range(99) < 10) begin
      m_readdatavalid = 1'b1;
      m_readdata = $urandom;
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata = $urandom;
    end
    if (auto_release) begin
      if (acc0) s0_read = 1'b0;
      if (acc1) begin s1_read = 1'b0; s1_write = 1'b0; end
    end
    if (rand_masters) rand_drive();
  endtask

  task automatic tick_b();
    @(negedge clk);
    acc0 = s0_read && !s0_waitrequest;
    acc1 = (s1_read || s1_write) && !s1_waitrequest;
    if (acc0) gseq.push_back(0);
    if (acc1) gseq.push_back(1);
    if (m_read && !m_waitrequest) begin
      for (int i = 0; i < ((m_burstcount == 0) ? 1 : int'(m_burstcount)); i++) begin
        rq.push_back(data_ctr);
        data_ctr++;
      end
    end
    if (from_q && m_readdatavalid) void'(rq.pop_front());
    if (s0_readdatavalid) s0_beats.push_back(s0_readdata);
    if (s1_readdatavalid) s1_vcnt++;
  endtask

  task automatic cyc();
    tick_a();
    tick_b();
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (!(rq.size() == 0 && own < 0 && !s0_read && !s1_read && !s1_write) && n < 500) begin
      cyc();
      n++;
    end
    if (n >= 500) timeout_fail("wait_quiet");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    reset_n = 1'b0;
    s0_address = '0; s0_read = 1'b0; s0_burstcount = BW'(1);
    s1_address = '0; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0; s1_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    tick_a();
    chk_en = 1'b1;
    tick_b();
    cyc();
    tick_a(); reset_n = 1'b1; tick_b();

    // reset values
    chk("rst_s0_waitrequest", s0_waitrequest, 1);
    chk("rst_s1_waitrequest", s1_waitrequest, 1);
    chk("rst_s0_rdv", s0_readdatavalid, 0);
    chk("rst_s1_rdv", s1_readdatavalid, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_burstcount", m_burstcount, 1);

    // scanout burst of 8 beats A0..A7
    rdv_pct = 70; data_ctr = 32'hA0; s0_beats.delete(); s1_vcnt = 0;
    tick_a(); s0_read = 1'b1; s0_address = AW'('h100); s0_burstcount = BW'(8); tick_b();
    n = 0;
    while (s0_beats.size() < 8 && n < 300) begin cyc(); n++; end
    if (n >= 300) timeout_fail("burst8_beats");
    tick_a(); s0_read = 1'b1; s0_address = AW'('h200); s0_burstcount = BW'(1); tick_b();
    chk("burst8_idle_after_last", m_read, 0);
    cyc();
    chk("burst8_next_grant_read", m_read, 1);
    chk("burst8_next_grant_addr", m_address, 'h200);
    for (int i = 0; i < 8; i++) chk("burst8_beat_data", (s0_beats.size() > i) ? s0_beats[i] : 'x, 32'hA0 + i);
    chk("burst8_s1_rdv_count", s1_vcnt, 0);
    wait_quiet();

    // raster write presented one cycle after request
    tick_a();
    s1_write = 1'b1; s1_address = AW'('h20); s1_writedata = 32'hDEADBEEF; s1_byteenable = 4'h3;
    tick_b();
    chk("wr_not_yet", m_write, 0);
    cyc();
    chk("wr_m_write", m_write, 1);
    chk("wr_burstcount", m_burstcount, 1);
    chk("wr_byteenable", m_byteenable, 4'h3);
    chk("wr_address", m_address, 'h20);
    chk("wr_data", m_writedata, 32'hDEADBEEF);
    wait_quiet();

    // fairness with both ports continuously requesting
    auto_release = 0; rdv_pct = 100; gseq.delete();
    tick_a();
    s0_read = 1'b1; s0_address = AW'('h300); s0_burstcount = BW'(1);
    s1_write = 1'b1; s1_address = AW'('h40); s1_writedata = 32'h1234; s1_byteenable = 4'hF;
    tick_b();
    n = 0;
    while (gseq.size() < 10 && n < 400) begin cyc(); n++; end
    if (n >= 400) timeout_fail("fair_seq");
    tick_a(); s0_read = 1'b0; s1_write = 1'b0; tick_b();
    auto_release = 1;
    for (int i = 0; i < 10; i++) chk("fair_grant_seq", (gseq.size() > i) ? gseq[i] : -1, exp_seq[i]);
    wait_quiet();

    // controller stalls raster for 5 cycles
    tick_a(); s1_read = 1'b1; s1_address = AW'('h55); tick_b();
    force_wait = 5;
    for (int i = 0; i < 5; i++) begin
      tick_a();
      if (i == 0) begin s0_read = 1'b1; s0_address = AW'('h66); s0_burstcount = BW'(2); end
      tick_b();
      chk("stall_s1_wait", s1_waitrequest, 1);
      chk("stall_s0_wait", s0_waitrequest, 1);
      chk("stall_m_read", m_read, 1);
      chk("stall_m_addr", m_address, 'h55);
    end
    cyc();
    chk("stall_accept_s1_wait", s1_waitrequest, 0);
    chk("stall_accept_m_read", m_read, 1);
    chk("stall_accept_s0_wait", s0_waitrequest, 1);
    wait_quiet();

    // reset after 3 of 8 beats
    rdv_pct = 100; s0_beats.delete();
    tick_a(); s0_read = 1'b1; s0_address = AW'('h400); s0_burstcount = BW'(8); tick_b();
    n = 0;
    while (s0_beats.size() < 3 && n < 100) begin cyc(); n++; end
    if (n >= 100) timeout_fail("rst_mid_beats");
    rdv_pct = 0;
    tick_a(); reset_n = 1'b0; tick_b();
    tick_a(); reset_n = 1'b1; rdv_pct = 100; tick_b();
    chk("rstmid_s0_wait", s0_waitrequest, 1);
    chk("rstmid_s1_wait", s1_waitrequest, 1);
    chk("rstmid_s0_rdv", s0_readdatavalid, 0);
    chk("rstmid_s1_rdv", s1_readdatavalid, 0);
    chk("rstmid_m_read", m_read, 0);
    chk("rstmid_m_write", m_write, 0);
    chk("rstmid_m_burstcount", m_burstcount, 1);
    repeat (10) cyc();
    chk("rstmid_beats_forwarded", s0_beats.size(), 3);
    chk("rstmid_ctrl_drained", rq.size(), 0);
    wait_quiet();

`ifdef SDRAM_ARB_STATS_EN
    tick_a(); stat_clear = 1'b1; tick_b();
    tick_a(); stat_clear = 1'b0; tick_b();
    for (int i = 0; i < 3; i++) begin
      tick_a(); s0_read = 1'b1; s0_address = AW'('h500 + i); s0_burstcount = BW'(2); tick_b();
      wait_quiet();
    end
    for (int i = 0; i < 2; i++) begin
      tick_a(); s1_write = 1'b1; s1_address = AW'('h600 + i); tick_b();
      wait_quiet();
    end
    chk("stats_grant0", stat_grant0, 3);
    chk("stats_grant1", stat_grant1, 2);
    chk("stats_stall1", stat_stall1, 2);
    tick_a(); stat_clear = 1'b1; tick_b();
    tick_a(); stat_clear = 1'b0; tick_b();
    chk("stats_clr_grant0", stat_grant0, 0);
    chk("stats_clr_grant1", stat_grant1, 0);
    chk("stats_clr_stall1", stat_stall1, 0);
`endif

    // randomized traffic against the model
    wait_pct = 30; rdv_pct = 60; spurious_en = 1; auto_release = 0; rand_masters = 1;
    repeat (3000) cyc();
    rand_masters = 0; spurious_en = 0; wait_pct = 0; rdv_pct = 100;
    tick_a();
    s0_read = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    tick_b();
    wait_quiet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_fb_arbiter.md
Name: sdram_fb_arbiter

Overview:
- Shares the single SDRAM Avalon-MM port between two requesters:
  - Port 0: VGA scanout reader. Burst reads only, high priority.
  - Port 1: GPU raster engine. Single-beat reads and writes.
- Sits between those masters and the SDRAM controller, in the system clock domain.
- Fixed priority to scanout, with a fairness limit so the raster engine is never starved.
- Read data is routed back to the current owner; the grant is held until all read beats return.

Parameters:
- AW, 25, word address width.
- DW, 32, data width.
- BW, 8, burstcount width.
- FAIR_LIMIT, 4, number of consecutive scanout grants allowed while port 1 waits; 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- s0_address  in  AW  scanout address.
- s0_read  in  1  scanout read request.
- s0_burstcount  in  BW  scanout burst length.
- s0_waitrequest  out  1  stall to scanout.
- s0_readdata  out  DW  read data to scanout.
- s0_readdatavalid  out  1  read beat valid to scanout.
- s1_address  in  AW  raster address.
- s1_read  in  1  raster read request.
- s1_write  in  1  raster write request.
- s1_writedata  in  DW  raster write data.
- s1_byteenable  in  DW/8  raster byte enables.
- s1_waitrequest  out  1  stall to raster.
- s1_readdata  out  DW  read data to raster.
- s1_readdatavalid  out  1  read beat valid to raster.
- m_address  out  AW  address to SDRAM controller.
- m_read  out  1  read command.
- m_write  out  1  write command.
- m_writedata  out  DW  write data.
- m_byteenable  out  DW/8  byte enables.
- m_burstcount  out  BW  burst length.
- m_waitrequest  in  1  controller stall.
- m_readdata  in  DW  read data from controller.
- m_readdatavalid  in  1  read beat valid from controller.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset_n is synchronous and active-low.
- Reset values:
  - State IDLE.
  - s0_waitrequest=1, s1_waitrequest=1.
  - readdatavalid outputs=0.
  - m_read=0, m_write=0, m_burstcount=1.
  - Beat counter=0, streak counter=0.
- States:
  - IDLE: no grant. Both waitrequests=1, m_read=0, m_write=0.
    - Arbitration is sampled here and the grant is registered.
    - If s0_read=1 and (streak<FAIR_LIMIT or s1 idle): go to G0.
    - Else if s1_read=1 or s1_write=1: go to G1.
    - Else stay in IDLE.
  - G0: s0 signals pass combinationally to m_*.
    - m_byteenable is all ones.
    - s0_waitrequest=m_waitrequest; s1_waitrequest=1.
    - On accept (m_read=1 and m_waitrequest=0): load the beat counter with s0_burstcount, where 0 is treated as 1, and go to DRAIN0.
    - On accept, streak increments (saturating) if s1 is requesting; otherwise it clears.
    - If s0_read drops before accept: go to IDLE.
  - G1: s1 signals pass to m_*; m_burstcount=1.
    - s1_waitrequest=m_waitrequest; s0_waitrequest=1.
    - Write accept: go to IDLE.
    - Read accept: beat counter=1, go to DRAIN1.
    - Any accept clears streak.
    - Request dropped before accept: go to IDLE.
  - DRAIN0 / DRAIN1:
    - No new command is issued and both waitrequests=1.
    - m_readdata and m_readdatavalid route to the owner. The non-owner's readdatavalid=0.
    - The counter decrements on each beat. When the last beat returns, go to IDLE.
- Latency:
  - A request seen in IDLE on cycle N is presented on m_* on cycle N+1.
  - After a transaction completes, at least one IDLE cycle separates grants.
  - Read data passes through combinationally, with zero added latency.
- Boundary conditions:
  - m_readdatavalid outside DRAIN is dropped; no output is asserted.
  - If s1_read=1 and s1_write=1 together, write takes priority.
  - If both ports request and streak==FAIR_LIMIT, port 1 is granted.
  - Reset mid-burst returns to IDLE immediately. Outstanding beats are discarded.
  - readdata outputs carry m_readdata unconditionally; only the valid signals are gated.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- When defined, adds the following outputs, all cleared on reset:
  - stat_grant0, 32 bits: count of s0 accepts.
  - stat_grant1, 32 bits: count of s1 accepts.
  - stat_stall1, 32 bits: count of cycles with an s1 request and s1_waitrequest=1.
  - Counters wrap at 2^32.
  - Input stat_clear (1 bit) zeroes all counters synchronously. When stat_clear coincides with an increment, the counter ends at 0.
- When not defined, these ports and registers are absent. The rest of the behaviour is identical.

Test Plan:
- s0 burst read, addr 0x100, burstcount 8, with the controller returning 8 beats 0xA0..0xA7:
  - s0 sees exactly 8 valid beats, in order.
  - s1_readdatavalid stays 0 throughout.
  - Return to IDLE on the cycle after the 8th beat.
- s1 write, addr 0x20, data 0xDEADBEEF, byteenable 0x3 -> m_write asserted one cycle after the request, with m_burstcount=1 and m_byteenable=0x3.
- s0 continuously requesting and s1 write pending, FAIR_LIMIT=4:
  - Grant sequence s0,s0,s0,s0,s1,s0...
  - Streak returns to 0 after the s1 grant.
- m_waitrequest held 1 for 5 cycles in G1:
  - s1_waitrequest=1 for those 5 cycles.
  - Command accepted on the 6th cycle.
  - s0 stays stalled throughout.
- reset_n pulsed low after 3 of 8 beats of a burst:
  - IDLE on the next cycle.
  - All outputs at reset values.
  - Remaining beats are not forwarded.
- With SDRAM_ARB_STATS_EN: 3 s0 bursts and 2 s1 writes -> stat_grant0=3, stat_grant1=2; stat_clear then returns all counters to 0.
